// File: rtl/usart_rx.sv
// Asynchronous serial receiver: start / data (LSB first) / optional parity / stop,
// sampled at mid-bit, delivered through a single-entry valid/ready output register.
module usart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  en_i,
   input  logic [DIV_WIDTH-1:0]  baud_div_i,
   input  logic                  rx_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  parity_err_o,
   output logic                  frame_err_o,
   output logic                  overrun_o,
   output logic [2:0]            state_o
);
   localparam int   IDX_W   = $clog2(DATA_WIDTH);
   localparam logic PAR_ODD = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state;
   logic                  rx_meta;
   logic                  rx_s;
   logic [DIV_WIDTH-1:0]  div;
   logic [DIV_WIDTH-1:0]  div_in;
   logic [DIV_WIDTH-1:0]  cnt;
   logic [DIV_WIDTH-1:0]  term;
   logic                  hit;
   logic [IDX_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shift;
   logic                  perr;
   logic                  ferr;
   logic                  done;

   assign state_o = state;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   // The start bit is sampled half a bit in so every later sample lands at mid-bit.
   always_comb begin
      div_in = (baud_div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div_i;
      term   = (state == S_START) ? ((div >> 1) - DIV_WIDTH'(1)) : (div - DIV_WIDTH'(1));
      hit    = (cnt == term);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         div     <= DIV_WIDTH'(4);
         bit_idx <= '0;
         shift   <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!en_i) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else if (state == S_IDLE) begin
            cnt <= '0;
            if (!rx_s) begin
               state <= S_START;
               div   <= div_in;
               perr  <= 1'b0;
            end
         end else if (!hit) begin
            cnt <= cnt + DIV_WIDTH'(1);
         end else begin
            cnt <= '0;
            case (state)
               S_START: begin
                  if (rx_s) begin
                     state <= S_IDLE;
                  end else begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end
               end
               S_DATA: begin
                  shift[bit_idx] <= rx_s;
                  if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                     state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
               S_PARITY: begin
                  perr  <= (^shift) ^ rx_s ^ PAR_ODD;
                  state <= S_STOP;
               end
               S_STOP: begin
                  ferr  <= !rx_s;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // valid/ready: a word is transferred on every clock where valid_o & ready_i; valid_o
   // never drops without a transfer, and data_o / flags are stable while valid_o is high.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         data_o       <= '0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (done) begin
            if (!valid_o || ready_i) begin
               data_o       <= shift;
               parity_err_o <= perr;
               frame_err_o  <= ferr;
               valid_o      <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: 8N1, 8E1 and 8O1 receivers fed directed and random frames; expected
// words go into one queue per receiver and a negedge monitor compares each presented word.
module tb_usart_rx;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          arst;
   logic          en;
   logic          ready;
   logic [15:0]   baud_div;
   logic          rx [3];
   logic [DW-1:0] data [3];
   logic          valid [3];
   logic          perr [3];
   logic          ferr [3];
   logic          ovr [3];
   logic [2:0]    st [3];

   logic [DW+1:0] exp_q [3][$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            rise_cyc [3];
   int            ovr_cnt [3];
   int            last_ovr_cyc [3];
   logic          prev_valid [3];
   logic          prev_ovr [3];
   logic          prev_ready = 1'b0;
   logic [DW+1:0] got;
   logic [DW+1:0] want;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   usart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .PARITY_EN(0), .PARITY_ODD(0)) u_n (
      .clk_i(clk), .arst_i(arst), .en_i(en), .baud_div_i(baud_div), .rx_i(rx[0]),
      .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready), .parity_err_o(perr[0]),
      .frame_err_o(ferr[0]), .overrun_o(ovr[0]), .state_o(st[0]));

   usart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(0)) u_e (
      .clk_i(clk), .arst_i(arst), .en_i(en), .baud_div_i(baud_div), .rx_i(rx[1]),
      .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready), .parity_err_o(perr[1]),
      .frame_err_o(ferr[1]), .overrun_o(ovr[1]), .state_o(st[1]));

   usart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(1)) u_o (
      .clk_i(clk), .arst_i(arst), .en_i(en), .baud_div_i(baud_div), .rx_i(rx[2]),
      .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready), .parity_err_o(perr[2]),
      .frame_err_o(ferr[2]), .overrun_o(ovr[2]), .state_o(st[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame on receiver 'dut' (bits change 1 ns after a rising edge) and, when the
   // word should reach the output register, pushes {parity_err, frame_err, data} first.
   task automatic send_frame(input int dut, input logic [DW-1:0] d, input bit par_bit,
                             input bit stop_bit, input int bitlen, input int gap,
                             input bit deliver, output int start_c);
      logic [DW+2:0] vec;
      int            n;
      bit            use_par;
      bit            odd;
      logic          pe;
      use_par = (dut != 0);
      odd     = (dut == 2);
      if (deliver) begin
         pe = use_par && ((($countones(d) + int'(par_bit) + int'(odd)) % 2) != 0);
         exp_q[dut].push_back({pe, ~stop_bit, d});
      end
      vec = '0;
      for (int k = 0; k < DW; k++) vec[k+1] = d[k];
      n = DW + 1;
      if (use_par) begin
         vec[n] = par_bit;
         n++;
      end
      vec[n] = stop_bit;
      n++;
      start_c = cyc;
      for (int b = 0; b < n; b++) begin
         rx[dut] = vec[b];
         tick(bitlen);
      end
      rx[dut] = 1'b1;
      tick(gap);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid[i] === 1'b1 && (!prev_valid[i] || prev_ready)) begin
            got = {perr[i], ferr[i], data[i]};
            rise_cyc[i] = cyc;
            checks++;
            if (exp_q[i].size() == 0) begin
               errors++;
               $display("FAIL unexpected_word dut%0d: got %0h expected none", i, got);
            end else begin
               want = exp_q[i].pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL word dut%0d: got {pe,fe,data}=%0h expected %0h", i, got, want);
               end
            end
         end
         if (ovr[i] === 1'b1) begin
            ovr_cnt[i]++;
            last_ovr_cyc[i] = cyc;
            if (prev_ovr[i]) begin
               checks++;
               errors++;
               $display("FAIL overrun_width dut%0d: got 2+ cycles expected 1", i);
            end
         end
         prev_valid[i] = valid[i];
         prev_ovr[i]   = ovr[i];
      end
      prev_ready = ready;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int  s1;
      int  s2;
      int  sc;
      int  ovr_base;
      int  bd;
      int  bl;
      int  dut;
      logic [DW-1:0] d;
      for (int i = 0; i < 3; i++) begin
         rx[i] = 1'b1;
         rise_cyc[i] = 0;
         ovr_cnt[i] = 0;
         last_ovr_cyc[i] = 0;
         prev_valid[i] = 1'b0;
         prev_ovr[i] = 1'b0;
      end
      arst = 1'b1;
      en = 1'b1;
      ready = 1'b0;
      baud_div = 16'd16;
      tick(3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_data%0d", i), 32'(data[i]), 0);
         check($sformatf("reset_flags%0d", i), {28'd0, valid[i], perr[i], ferr[i], ovr[i]}, 0);
         check($sformatf("reset_state%0d", i), 32'(st[i]), 0);
      end
      arst = 1'b0;
      tick(4);

      // basic 8N1 frame, D = 16, consumer stalled
      send_frame(0, 8'hA5, 1'b0, 1'b1, 16, 20, 1'b1, s1);
      check("basic_rise_edge", rise_cyc[0], s1 + 156);
      check("basic_hold_valid", 32'(valid[0]), 1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("basic_clear", 32'(valid[0]), 0);

      // parity
      ready = 1'b1;
      send_frame(1, 8'h03, 1'b0, 1'b1, 16, 20, 1'b1, sc);
      check("parity_even_ok", 32'(perr[1]), 0);
      send_frame(1, 8'h03, 1'b1, 1'b1, 16, 20, 1'b1, sc);
      check("parity_even_err", 32'(perr[1]), 1);
      send_frame(2, 8'h03, 1'b1, 1'b1, 16, 20, 1'b1, sc);
      check("parity_odd_ok", 32'(perr[2]), 0);

      // framing error and false start
      send_frame(0, 8'h5A, 1'b0, 1'b0, 16, 32, 1'b1, sc);
      check("frame_err", 32'(ferr[0]), 1);
      check("frame_err_data", 32'(data[0]), 32'h5A);
      rx[0] = 1'b0;
      tick(3);
      rx[0] = 1'b1;
      tick(32);
      check("glitch_idle", 32'(st[0]), 0);
      check("glitch_no_valid", 32'(valid[0]), 0);

      // overrun with back-to-back frames, then the same pair with a ready consumer
      ready = 1'b0;
      ovr_base = ovr_cnt[0];
      send_frame(0, 8'h11, 1'b0, 1'b1, 16, 0, 1'b1, s1);
      send_frame(0, 8'h22, 1'b0, 1'b1, 16, 20, 1'b0, s2);
      check("overrun_count", ovr_cnt[0] - ovr_base, 1);
      check("overrun_time", last_ovr_cyc[0], s2 + 156);
      check("overrun_keep_data", 32'(data[0]), 32'h11);
      check("overrun_keep_valid", 32'(valid[0]), 1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("overrun_drain", 32'(valid[0]), 0);
      ready = 1'b1;
      ovr_base = ovr_cnt[0];
      send_frame(0, 8'h11, 1'b0, 1'b1, 16, 0, 1'b1, sc);
      send_frame(0, 8'h22, 1'b0, 1'b1, 16, 20, 1'b1, sc);
      check("b2b_no_overrun", ovr_cnt[0] - ovr_base, 0);

      // divisor corners
      baud_div = 16'd2;
      for (int i = 0; i < 3; i++) begin
         d = DW'($urandom_range(0, 255));
         send_frame(0, d, 1'b0, 1'b1, 4, 10, 1'b1, sc);
      end
      baud_div = 16'd16;
      fork
         send_frame(0, 8'hC3, 1'b0, 1'b1, 16, 24, 1'b1, sc);
         begin
            tick(40);
            baud_div = 16'd8;
         end
      join
      baud_div = 16'd16;

      // asynchronous reset during bit 4 while a word is held
      ready = 1'b0;
      send_frame(0, 8'h3C, 1'b0, 1'b1, 16, 20, 1'b1, sc);
      fork
         send_frame(0, 8'hF5, 1'b0, 1'b1, 16, 32, 1'b0, sc);
         begin
            tick(88);
            arst = 1'b1;
            #1;
            check("midreset_data", 32'(data[0]), 0);
            check("midreset_flags", {29'd0, valid[0], perr[0], ferr[0]}, 0);
            check("midreset_overrun", 32'(ovr[0]), 0);
            tick(2);
            arst = 1'b0;
            check("midreset_state", 32'(st[0]), 0);
         end
      join
      ready = 1'b1;
      send_frame(0, 8'h96, 1'b0, 1'b1, 16, 20, 1'b1, sc);

      // enable dropped for one cycle during bit 4
      fork
         send_frame(0, 8'hF5, 1'b0, 1'b1, 16, 32, 1'b0, sc);
         begin
            tick(88);
            en = 1'b0;
            tick(1);
            en = 1'b1;
            check("en_drop_idle", 32'(st[0]), 0);
         end
      join
      send_frame(0, 8'h7E, 1'b0, 1'b1, 16, 20, 1'b1, sc);

      // random frames, random divisor (including clamped values) and stop bit
      for (int i = 0; i < 12; i++) begin
         bd = $urandom_range(0, 24);
         baud_div = 16'(bd);
         bl = (bd < 4) ? 4 : bd;
         d = DW'($urandom_range(0, 255));
         send_frame(0, d, 1'b0, ($urandom_range(0, 3) != 0), bl, 2 * bl + 4, 1'b1, sc);
      end
      for (int i = 0; i < 12; i++) begin
         dut = $urandom_range(1, 2);
         bl = $urandom_range(4, 20);
         baud_div = 16'(bl);
         d = DW'($urandom_range(0, 255));
         send_frame(dut, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), bl,
                    2 * bl + 4, 1'b1, sc);
      end

      tick(50);
      for (int i = 0; i < 3; i++) check($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
      check("overrun_total", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2], 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usart_rx.md
# usart_rx

Serial receiver of the AXI USART: recovers asynchronous frames (start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit) from the `rx_i` line and presents each word on a single-entry valid/ready output register. It is the receive-side counterpart of the USART transmitter. The bit period comes from the same run-time divisor register the transmitter uses. Framing, parity and overrun errors are reported per frame.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- DIV_WIDTH, 16, width of the bit-period divisor
- PARITY_EN, 0, 1 = parity bit present after data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)

- clk_i  in  1  system clock
- arst_i  in  1  asynchronous, active-high reset
- en_i  in  1  receiver enable; low aborts any frame and holds the receiver in IDLE
- baud_div_i  in  DIV_WIDTH  clocks per bit D; values below 4 are treated as 4
- rx_i  in  1  asynchronous serial line, idle high
- data_o  out  DATA_WIDTH  received word
- valid_o  out  1  data_o holds an unconsumed word
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i
- parity_err_o  out  1  parity mismatch for the word in data_o
- frame_err_o  out  1  stop bit sampled 0 for the word in data_o
- overrun_o  out  1  one-cycle pulse: a frame completed while valid_o was high

## Operation
- rx_i passes through a 2-FF synchronizer (both stages reset to 1), giving rx_s. All decisions use rx_s.
- D is latched on start detection. Changes to baud_div_i mid-frame have no effect.
- Bit counter cnt and terminal value T: a sample is taken on the cycle cnt == T, and cnt clears on that cycle.
- States:
  - IDLE: cnt = 0. If en_i & !rx_s, go to START.
  - START: T = (D>>1) - 1. At the sample: if rx_s = 1 (false start), go to IDLE; else go to DATA with bit index 0.
  - DATA: T = D - 1. Shift rx_s into bit[index], LSB first. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: T = D - 1. Parity error is set if (XOR of data ^ rx_s ^ PARITY_ODD) != 0. Go to STOP.
  - STOP: T = D - 1. Frame error = !rx_s. Then go to IDLE. A new start is detected on the next cycle, so back-to-back frames with no idle bit are received.
- Completion (the cycle after the stop sample):
  - If valid_o = 0: load data_o, parity_err_o and frame_err_o, and set valid_o.
  - If valid_o = 1: discard the new word, pulse overrun_o, and leave data_o and the flags unchanged.
- valid_o clears on the cycle after valid_o & ready_i. If completion and acceptance occur in the same cycle, the new word loads and valid_o stays 1, with no overrun.
- en_i low in any state: go to IDLE next cycle; the partial word is dropped. The output register is unaffected.
- Reset (async, any time, including mid-frame): state IDLE, synchronizer = 1, cnt = 0, data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, overrun_o = 0.

## Timing
- Let edge 0 be the first clk_i edge at which rx_i is sampled low.
- Start detected at edge 2; start sampled at edge 2 + D/2.
- Data bit k sampled at edge 2 + D/2 + (k+1)·D.
- valid_o rises at edge 3 + D/2 + (DATA_WIDTH + PARITY_EN + 1)·D.
- Sample points sit at mid-bit, which tolerates ±(D/2 - 2) cycles of accumulated drift.
- All outputs are registered. overrun_o is high for exactly one cycle.

## Test plan
- Basic frame: D = 16, 8N1, send 0xA5 with ready_i held 0. Require valid_o rising at edge 155, data_o = 0xA5, both error flags 0, and valid_o staying high until ready_i is pulsed, then clearing one cycle later.
- Parity: PARITY_EN = 1, even parity.
  - Send 0x03 with parity bit 0: parity_err_o = 0.
  - Send 0x03 with parity bit 1: parity_err_o = 1.
  - With odd parity, the 0x03 / parity 1 frame gives parity_err_o = 0.
- Framing and false start:
  - 0x5A with stop bit 0: frame_err_o = 1, data_o = 0x5A.
  - A 3-cycle low glitch on rx_i (D = 16): no valid_o, and the receiver is back in IDLE.
- Overrun and back-to-back: send 0x11 then 0x22 with no idle gap and ready_i = 0.
  - data_o stays 0x11, and overrun_o pulses one cycle at the second completion.
  - Repeat with ready_i = 1 throughout: both words are delivered in order with no overrun.
- Divisor corners: baud_div_i = 2 behaves exactly as D = 4. Changing baud_div_i from 16 to 8 mid-frame still yields the correct 0xC3.
- Reset/enable mid-frame:
  - Assert arst_i during bit 4: all outputs drop to 0 immediately.
  - Drop en_i for one cycle during bit 4: no word is delivered, and the next full frame 0x7E is received correctly.
